// File: rtl/cnn_layer_controller_if.sv
// BRAM-side bus of the CNN layer controller: address, write strobe and both data directions.
// The controller drives the address and write data; the memory returns read data one cycle later.
interface cnn_layer_controller_if #(
    parameter int width      = 8,
    parameter int memaddrbit = 17
);
    logic [memaddrbit-1:0] memaddr;
    logic                  wea;
    logic [width-1:0]      mem_in;
    logic [width-1:0]      mem_out;

    modport master (output memaddr, output wea, output mem_in, input mem_out);
    modport slave  (input memaddr, input wea, input mem_in, output mem_out);
endinterface

// File: rtl/cnn_layer_controller.sv
// One CNN layer over a shared single-port BRAM: direct convolution with a signed fixed-point MAC,
// then optional max pooling of the resulting feature map into a second region.
module cnn_layer_controller #(
    parameter int width      = 8,
    parameter int decimal    = 4,
    parameter int memaddrbit = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    // d_o is the conv out-channel count ("do" is a reserved word)
    input  logic [memaddrbit-1:0]  d_o, di, dr, dc, dkr, dkc,
    input  logic [2:0]             step,
    input  logic                   relu,
    input  logic [memaddrbit-1:0]  inaddr, waddr, outaddr, dr_out, dc_out,
    input  logic                   maxpooling_or_not,
    input  logic [2:0]             mp_step,
    input  logic [memaddrbit-1:0]  mp_dkr, mp_dkc, mp_dr, mp_dc, mp_di, mp_dr_out, mp_dc_out,
    input  logic [memaddrbit-1:0]  mp_inaddr, mp_outaddr,
    cnn_layer_controller_if.master mem,
    output logic [7:0]             state,
    output logic                   picture_finish,
    output logic                   mp_picture_finish,
    output logic                   mp_enable,
    output logic                   busy
);
    localparam int A    = memaddrbit;
    localparam int ACCW = 2 * width + 8;
    localparam logic [A-1:0]     ONE     = {{(A-1){1'b0}}, 1'b1};
    localparam logic [width-1:0] VAL_MIN = {1'b1, {(width-1){1'b0}}};
    localparam logic [width-1:0] VAL_MAX = {1'b0, {(width-1){1'b1}}};

    typedef enum logic [3:0] {
        IDLE  = 4'd0, C_RDI = 4'd1, C_RDW = 4'd2, C_MAC = 4'd3, C_WR = 4'd4,
        P_RD  = 4'd5, P_CMP = 4'd6, P_WR  = 4'd7, DONE  = 4'd8
    } state_t;

    state_t state_reg;
    // ir/ic/ii/ikr/ikc are shared by the conv and pool phases, which never overlap
    logic [A-1:0] io_reg, ir_reg, ic_reg, ii_reg, ikr_reg, ikc_reg;
    logic [width-1:0] in_op_reg, max_reg, mem_in_reg;
    logic signed [ACCW-1:0] acc_reg;
    logic [A-1:0] memaddr_reg;
    logic wea_reg, pf_reg, mpf_reg, mp_en_reg, busy_reg;

    logic [A-1:0] step_a, mp_step_a;
    assign step_a    = {{(A-3){1'b0}}, step};
    assign mp_step_a = {{(A-3){1'b0}}, mp_step};

    function automatic logic [A-1:0] conv_in_addr(input logic [A-1:0] ii, ir, ic, ikr, ikc);
        return inaddr + ii * dr * dc + (ir * step_a + ikr) * dc + ic * step_a + ikc;
    endfunction

    function automatic logic [A-1:0] conv_w_addr(input logic [A-1:0] io, ii, ikr, ikc);
        return waddr + ((io * di + ii) * dkr + ikr) * dkc + ikc;
    endfunction

    function automatic logic [A-1:0] conv_out_addr(input logic [A-1:0] io, ir, ic);
        return outaddr + io * dr_out * dc_out + ir * dc_out + ic;
    endfunction

    function automatic logic [A-1:0] mp_src_addr(input logic [A-1:0] ii, ir, ic, ikr, ikc);
        return mp_inaddr + ii * mp_dr * mp_dc + (ir * mp_step_a + ikr) * mp_dc + ic * mp_step_a + ikc;
    endfunction

    function automatic logic [A-1:0] mp_dst_addr(input logic [A-1:0] ii, ir, ic);
        return mp_outaddr + ii * mp_dr_out * mp_dc_out + ir * mp_dc_out + ic;
    endfunction

    // Loop odometers: next index values and wrap flags for each nest
    logic [A-1:0] tap_ii_next, tap_ikr_next, tap_ikc_next;
    logic [A-1:0] pix_io_next, pix_ir_next, pix_ic_next;
    logic [A-1:0] win_ikr_next, win_ikc_next;
    logic [A-1:0] pp_ii_next, pp_ir_next, pp_ic_next;
    logic tap_last, pix_last, win_last, pp_last;

    always_comb begin
        tap_ikc_next = ikc_reg + ONE;
        tap_ikr_next = ikr_reg;
        tap_ii_next  = ii_reg;
        tap_last     = 1'b0;
        if (ikc_reg == dkc - ONE) begin
            tap_ikc_next = '0;
            tap_ikr_next = ikr_reg + ONE;
            if (ikr_reg == dkr - ONE) begin
                tap_ikr_next = '0;
                tap_ii_next  = ii_reg + ONE;
                tap_last     = (ii_reg == di - ONE);
            end
        end

        pix_ic_next = ic_reg + ONE;
        pix_ir_next = ir_reg;
        pix_io_next = io_reg;
        pix_last    = 1'b0;
        if (ic_reg == dc_out - ONE) begin
            pix_ic_next = '0;
            pix_ir_next = ir_reg + ONE;
            if (ir_reg == dr_out - ONE) begin
                pix_ir_next = '0;
                pix_io_next = io_reg + ONE;
                pix_last    = (io_reg == d_o - ONE);
            end
        end

        win_ikc_next = ikc_reg + ONE;
        win_ikr_next = ikr_reg;
        win_last     = 1'b0;
        if (ikc_reg == mp_dkc - ONE) begin
            win_ikc_next = '0;
            win_ikr_next = ikr_reg + ONE;
            win_last     = (ikr_reg == mp_dkr - ONE);
        end

        pp_ic_next = ic_reg + ONE;
        pp_ir_next = ir_reg;
        pp_ii_next = ii_reg;
        pp_last    = 1'b0;
        if (ic_reg == mp_dc_out - ONE) begin
            pp_ic_next = '0;
            pp_ir_next = ir_reg + ONE;
            if (ir_reg == mp_dr_out - ONE) begin
                pp_ir_next = '0;
                pp_ii_next = ii_reg + ONE;
                pp_last    = (ii_reg == mp_di - ONE);
            end
        end
    end

    // MAC datapath: the weight arrives on mem_out during C_MAC and is used directly
    logic signed [2*width-1:0] prod;
    logic signed [ACCW-1:0]    acc_sum, acc_shift;
    logic [ACCW-width:0]       acc_hi;
    logic [width-1:0]          conv_sat, conv_res, pool_max;

    always_comb begin
        prod      = $signed({{width{in_op_reg[width-1]}}, in_op_reg})
                  * $signed({{width{mem.mem_out[width-1]}}, mem.mem_out});
        acc_sum   = acc_reg + $signed({{8{prod[2*width-1]}}, prod});
        acc_shift = acc_sum >>> decimal;
        acc_hi    = acc_shift[ACCW-1:width-1];
        if ((&acc_hi) || !(|acc_hi))
            conv_sat = acc_shift[width-1:0];
        else
            conv_sat = acc_shift[ACCW-1] ? VAL_MIN : VAL_MAX;
        conv_res = (relu && conv_sat[width-1]) ? '0 : conv_sat;
        pool_max = ($signed(mem.mem_out) > $signed(max_reg)) ? mem.mem_out : max_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            io_reg      <= '0;
            ir_reg      <= '0;
            ic_reg      <= '0;
            ii_reg      <= '0;
            ikr_reg     <= '0;
            ikc_reg     <= '0;
            in_op_reg   <= '0;
            acc_reg     <= '0;
            max_reg     <= '0;
            memaddr_reg <= '0;
            wea_reg     <= 1'b0;
            mem_in_reg  <= '0;
            pf_reg      <= 1'b0;
            mpf_reg     <= 1'b0;
            mp_en_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            pf_reg  <= 1'b0;
            mpf_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    memaddr_reg <= '0;
                    wea_reg     <= 1'b0;
                    if (start) begin
                        state_reg   <= C_RDI;
                        busy_reg    <= 1'b1;
                        io_reg      <= '0;
                        ir_reg      <= '0;
                        ic_reg      <= '0;
                        ii_reg      <= '0;
                        ikr_reg     <= '0;
                        ikc_reg     <= '0;
                        acc_reg     <= '0;
                        memaddr_reg <= inaddr;
                    end
                end
                C_RDI: begin
                    state_reg   <= C_RDW;
                    memaddr_reg <= conv_w_addr(io_reg, ii_reg, ikr_reg, ikc_reg);
                end
                C_RDW: begin
                    state_reg <= C_MAC;
                    in_op_reg <= mem.mem_out;
                end
                C_MAC: begin
                    acc_reg <= acc_sum;
                    if (tap_last) begin
                        state_reg   <= C_WR;
                        ii_reg      <= '0;
                        ikr_reg     <= '0;
                        ikc_reg     <= '0;
                        wea_reg     <= 1'b1;
                        mem_in_reg  <= conv_res;
                        memaddr_reg <= conv_out_addr(io_reg, ir_reg, ic_reg);
                    end else begin
                        state_reg   <= C_RDI;
                        ii_reg      <= tap_ii_next;
                        ikr_reg     <= tap_ikr_next;
                        ikc_reg     <= tap_ikc_next;
                        memaddr_reg <= conv_in_addr(tap_ii_next, ir_reg, ic_reg, tap_ikr_next, tap_ikc_next);
                    end
                end
                C_WR: begin
                    wea_reg    <= 1'b0;
                    mem_in_reg <= '0;
                    acc_reg    <= '0;
                    if (pix_last) begin
                        pf_reg <= 1'b1;
                        io_reg <= '0;
                        ir_reg <= '0;
                        ic_reg <= '0;
                        if (maxpooling_or_not) begin
                            state_reg   <= P_RD;
                            mp_en_reg   <= 1'b1;
                            max_reg     <= VAL_MIN;
                            memaddr_reg <= mp_inaddr;
                        end else begin
                            state_reg   <= DONE;
                            memaddr_reg <= '0;
                        end
                    end else begin
                        state_reg   <= C_RDI;
                        io_reg      <= pix_io_next;
                        ir_reg      <= pix_ir_next;
                        ic_reg      <= pix_ic_next;
                        memaddr_reg <= conv_in_addr('0, pix_ir_next, pix_ic_next, '0, '0);
                    end
                end
                P_RD: state_reg <= P_CMP;
                P_CMP: begin
                    if (win_last) begin
                        state_reg   <= P_WR;
                        ikr_reg     <= '0;
                        ikc_reg     <= '0;
                        max_reg     <= VAL_MIN;
                        wea_reg     <= 1'b1;
                        mem_in_reg  <= pool_max;
                        memaddr_reg <= mp_dst_addr(ii_reg, ir_reg, ic_reg);
                    end else begin
                        state_reg   <= P_RD;
                        max_reg     <= pool_max;
                        ikr_reg     <= win_ikr_next;
                        ikc_reg     <= win_ikc_next;
                        memaddr_reg <= mp_src_addr(ii_reg, ir_reg, ic_reg, win_ikr_next, win_ikc_next);
                    end
                end
                P_WR: begin
                    wea_reg    <= 1'b0;
                    mem_in_reg <= '0;
                    if (pp_last) begin
                        state_reg   <= DONE;
                        mpf_reg     <= 1'b1;
                        mp_en_reg   <= 1'b0;
                        ii_reg      <= '0;
                        ir_reg      <= '0;
                        ic_reg      <= '0;
                        memaddr_reg <= '0;
                    end else begin
                        state_reg   <= P_RD;
                        ii_reg      <= pp_ii_next;
                        ir_reg      <= pp_ir_next;
                        ic_reg      <= pp_ic_next;
                        memaddr_reg <= mp_src_addr(pp_ii_next, pp_ir_next, pp_ic_next, '0, '0);
                    end
                end
                DONE: begin
                    state_reg   <= IDLE;
                    busy_reg    <= 1'b0;
                    memaddr_reg <= '0;
                end
                default: begin
                    state_reg   <= IDLE;
                    busy_reg    <= 1'b0;
                    wea_reg     <= 1'b0;
                    mp_en_reg   <= 1'b0;
                    memaddr_reg <= '0;
                end
            endcase
        end
    end

    assign state             = {4'd0, state_reg};
    assign mem.memaddr       = memaddr_reg;
    assign mem.wea           = wea_reg;
    assign mem.mem_in        = mem_in_reg;
    assign picture_finish    = pf_reg;
    assign mp_picture_finish = mpf_reg;
    assign mp_enable         = mp_en_reg;
    assign busy              = busy_reg;
endmodule

// File: tb/tb_cnn_layer_controller.sv
// Directed bench for cnn_layer_controller with a behavioural 1-cycle-latency BRAM and a bus monitor.
// Expected addresses, data and cycle counts are hand-computed from the layer geometry.
module tb_cnn_layer_controller;
    localparam int W = 8;
    localparam int A = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic [A-1:0] d_o, di, dr, dc, dkr, dkc, inaddr, waddr, outaddr, dr_out, dc_out;
    logic [A-1:0] mp_dkr, mp_dkc, mp_dr, mp_dc, mp_di, mp_dr_out, mp_dc_out, mp_inaddr, mp_outaddr;
    logic [2:0] step, mp_step;
    logic relu, maxpooling_or_not;
    logic [7:0] state;
    logic picture_finish, mp_picture_finish, mp_enable, busy;

    cnn_layer_controller_if #(.width(W), .memaddrbit(A)) bus ();

    cnn_layer_controller #(.width(W), .decimal(4), .memaddrbit(A)) dut (
        .clk(clk), .rst(rst), .start(start),
        .d_o(d_o), .di(di), .dr(dr), .dc(dc), .dkr(dkr), .dkc(dkc),
        .step(step), .relu(relu),
        .inaddr(inaddr), .waddr(waddr), .outaddr(outaddr), .dr_out(dr_out), .dc_out(dc_out),
        .maxpooling_or_not(maxpooling_or_not), .mp_step(mp_step),
        .mp_dkr(mp_dkr), .mp_dkc(mp_dkc), .mp_dr(mp_dr), .mp_dc(mp_dc), .mp_di(mp_di),
        .mp_dr_out(mp_dr_out), .mp_dc_out(mp_dc_out),
        .mp_inaddr(mp_inaddr), .mp_outaddr(mp_outaddr),
        .mem(bus), .state(state), .picture_finish(picture_finish),
        .mp_picture_finish(mp_picture_finish), .mp_enable(mp_enable), .busy(busy)
    );

    // BRAM model; the bench preloads it through the fill port while the DUT is idle
    logic [7:0] ram [0:(1<<A)-1];
    logic fill_en = 1'b0;
    logic [A-1:0] fill_addr = '0;
    logic [7:0] fill_data = '0;
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fill_en) ram[fill_addr] <= fill_data;
        else if (bus.wea) ram[bus.memaddr] <= bus.mem_in;
        bus.mem_out <= ram[bus.memaddr];
    end

    int wr_addr[$], wr_data[$], wr_cyc[$], rd_addr[$], rd_cyc[$], pf_cyc[$], mpf_cyc[$];
    int mp_en_cnt = 0, mp_viol = 0, wea_viol = 0, busy_viol = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wea) begin
                wr_addr.push_back(int'(bus.memaddr));
                wr_data.push_back(int'(bus.mem_in));
                wr_cyc.push_back(cyc);
            end
            if (state == 8'd1) begin
                rd_addr.push_back(int'(bus.memaddr));
                rd_cyc.push_back(cyc);
            end
            if (picture_finish) pf_cyc.push_back(cyc);
            if (mp_picture_finish) mpf_cyc.push_back(cyc);
            if (mp_enable) mp_en_cnt <= mp_en_cnt + 1;
            if (mp_enable != (state >= 8'd5 && state <= 8'd7)) mp_viol <= mp_viol + 1;
            if (bus.wea != (state == 8'd4 || state == 8'd7)) wea_viol <= wea_viol + 1;
            if (busy != (state != 8'd0)) busy_viol <= busy_viol + 1;
        end
    end

    int n_run = 0, n_fail = 0;
    int wb, rb, pb, mb, me0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] pass %s = 0x%0h", tag, got);
        end
    endtask

    task automatic fill(input int base, input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            fill_en = 1'b1; fill_addr = A'(base + i); fill_data = v;
        end
        @(negedge clk);
        fill_en = 1'b0;
    endtask

    task automatic mark();
        wb = wr_addr.size(); rb = rd_addr.size(); pb = pf_cyc.size();
        mb = mpf_cyc.size(); me0 = mp_en_cnt;
    endtask

    task automatic run_layer(input string tag, input int max_cyc);
        bit done;
        mark();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        done = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (state == 8'd0) begin done = 1'b1; break; end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic conv_cfg(input int o, input int i, input int r, input int c, input int k,
                            input int s, input int ro, input int co);
        d_o = A'(o); di = A'(i); dr = A'(r); dc = A'(c); dkr = A'(k); dkc = A'(k);
        step = 3'(s); dr_out = A'(ro); dc_out = A'(co);
    endtask

    logic [7:0] pool_vals [0:15] = '{8'hFB, 8'h03, 8'h01, 8'h02, 8'hFF, 8'h07, 8'h09, 8'hFD,
                                     8'hF8, 8'hF9, 8'h00, 8'h80, 8'hFA, 8'hF7, 8'h7F, 8'h05};
    int exp_rd [0:8] = '{0, 2, 4, 10, 12, 14, 20, 22, 24};
    int exp_pool [0:3] = '{8'h07, 8'h09, 8'hFA, 8'h7F};

    initial begin
        int bad;
        bit hit;
        conv_cfg(1, 1, 3, 3, 2, 1, 2, 2);
        relu = 1'b0; maxpooling_or_not = 1'b0;
        inaddr = A'(100); waddr = A'(200); outaddr = A'(300);
        mp_step = 3'd2; mp_dkr = A'(2); mp_dkc = A'(2); mp_dr = A'(4); mp_dc = A'(4); mp_di = A'(1);
        mp_dr_out = A'(2); mp_dc_out = A'(2); mp_inaddr = A'(400); mp_outaddr = A'(500);
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wea", 32'(bus.wea), 32'd0);
        check("rst_memaddr", 32'(bus.memaddr), 32'd0);
        rst = 1'b0;

        // Reset in the middle of a MAC, then a clean restart
        fill(100, 9, 8'h10);
        fill(200, 4, 8'h10);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (state == 8'd3) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        check("t1_reach_mac", 32'(hit), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t1_state_after_rst", 32'(state), 32'd0);
        check("t1_wea_after_rst", 32'(bus.wea), 32'd0);
        check("t1_busy_after_rst", 32'(busy), 32'd0);
        @(negedge clk); rst = 1'b0;

        // 2x2 kernel over 3x3, all ones in Q4.4
        run_layer("t2", 300);
        check("t2_nwrites", 32'(wr_addr.size() - wb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_addr%0d", i), 32'(wr_addr[wb+i]), 32'(300 + i));
            check($sformatf("t2_data%0d", i), 32'(wr_data[wb+i]), 32'h40);
            if (i > 0) check($sformatf("t2_gap%0d", i), 32'(wr_cyc[wb+i] - wr_cyc[wb+i-1]), 32'd13);
        end
        check("t2_first_rd_addr", 32'(rd_addr[rb]), 32'd100);
        check("t2_pf_count", 32'(pf_cyc.size() - pb), 32'd1);
        check("t2_pf_latency", 32'(pf_cyc[pb] - rd_cyc[rb]), 32'd52);
        check("t2_no_pool", 32'(mp_en_cnt - me0), 32'd0);

        // Saturation and relu
        fill(100, 9, 8'h70);
        fill(200, 4, 8'h70);
        run_layer("t3a", 300);
        for (int i = 0; i < 4; i++)
            check($sformatf("t3_sat%0d", i), 32'(wr_data[wb+i]), 32'h7F);
        fill(100, 9, 8'h10);
        fill(200, 4, 8'hF0);
        run_layer("t3b", 300);
        check("t3_neg_norelu", 32'(wr_data[wb]), 32'hC0);
        relu = 1'b1;
        run_layer("t3c", 300);
        check("t3_neg_relu", 32'(wr_data[wb]), 32'h00);
        relu = 1'b0;

        // Stride 2, 1x1 kernel over 5x5
        conv_cfg(1, 1, 5, 5, 1, 2, 3, 3);
        fill(100, 25, 8'h01);
        run_layer("t4", 300);
        check("t4_nreads", 32'(rd_addr.size() - rb), 32'd9);
        check("t4_nwrites", 32'(wr_addr.size() - wb), 32'd9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("t4_rd%0d", i), 32'(rd_addr[rb+i]), 32'(100 + exp_rd[i]));
            check($sformatf("t4_wr%0d", i), 32'(wr_addr[wb+i]), 32'(300 + i));
        end

        // 1x1 conv followed by 2x2/2 pooling over a 4x4 map
        conv_cfg(1, 1, 1, 1, 1, 1, 1, 1);
        maxpooling_or_not = 1'b1;
        fill(100, 1, 8'h10);
        fill(200, 1, 8'h10);
        for (int i = 0; i < 16; i++) fill(400 + i, 1, pool_vals[i]);
        run_layer("t5", 300);
        check("t5_nwrites", 32'(wr_addr.size() - wb), 32'd5);
        check("t5_conv_data", 32'(wr_data[wb]), 32'h10);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_addr%0d", i), 32'(wr_addr[wb+1+i]), 32'(500 + i));
            check($sformatf("t5_max%0d", i), 32'(wr_data[wb+1+i]), 32'(exp_pool[i]));
        end
        check("t5_mp_en_cycles", 32'(mp_en_cnt - me0), 32'd36);
        check("t5_mpf_count", 32'(mpf_cyc.size() - mb), 32'd1);
        check("t5_pf_count", 32'(pf_cyc.size() - pb), 32'd1);

        // Full-geometry layer with two output channels
        conv_cfg(2, 3, 15, 15, 4, 1, 12, 12);
        inaddr = A'(2); waddr = A'(677); outaddr = A'(1061);
        mp_dr = A'(12); mp_dc = A'(12); mp_di = A'(2); mp_dr_out = A'(6); mp_dc_out = A'(6);
        mp_inaddr = A'(1061); mp_outaddr = A'(2213);
        run_layer("t6", 50000);
        check("t6_nwrites", 32'(wr_addr.size() - wb), 32'd360);
        bad = 0;
        for (int i = 0; i < 288; i++) if (wr_addr[wb+i] != 1061 + i) bad++;
        for (int i = 0; i < 72; i++) if (wr_addr[wb+288+i] != 2213 + i) bad++;
        check("t6_addr_mismatches", 32'(bad), 32'd0);
        check("t6_conv_last", 32'(wr_addr[wb+287]), 32'd1348);
        check("t6_pool_last", 32'(wr_addr[wb+359]), 32'd2284);
        check("t6_pf_latency", 32'(pf_cyc[pb] - rd_cyc[rb]), 32'(288 * 145));
        check("t6_mpf_count", 32'(mpf_cyc.size() - mb), 32'd1);

        check("mp_enable_only_in_pool", 32'(mp_viol), 32'd0);
        check("wea_only_in_write", 32'(wea_viol), 32'd0);
        check("busy_tracks_state", 32'(busy_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
